// File: rtl/gray_adaptive_binarizer_if.sv
// Pixel stream bundle for gray_adaptive_binarizer.
//   s_* : upstream gray pixel stream (valid/ready, gray, sof, eol)
//   m_* : downstream masked pixel stream (valid/ready, gray, mask, sof, eol)
// Modports:
//   slave  - the binarizer: consumes s_*, produces m_*
//   master - the environment: produces s_*, consumes m_*
interface gray_adaptive_binarizer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_gray;
    logic       s_sof;
    logic       s_eol;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_gray;
    logic       m_mask;
    logic       m_sof;
    logic       m_eol;

    modport slave (
        input  s_valid, s_gray, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_gray, m_mask, m_sof, m_eol
    );

    modport master (
        output s_valid, s_gray, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_gray, m_mask, m_sof, m_eol
    );
endinterface

// File: rtl/gray_adaptive_binarizer.sv
// Adaptive binarizer: passes 8-bit gray pixels through with a foreground mask
// (gray >= threshold). The threshold is the mean gray level of the previous
// complete frame, computed by a restoring divider after each frame ends and
// applied from the next start-of-frame.
// Ports:
//   clk, rst_n   - pixel clock, asynchronous active-low reset
//   bus          - stream bundle (slave modport): s_* in, m_* out, 1-cycle latency
//   thresh       - threshold currently applied
//   frame_err    - one-cycle pulse on short/long frame or dropped end-of-frame
// Optional feature macro THRESH_OVERRIDE_EN adds thr_ovr_en / thr_ovr_val, which
// replace the threshold cycle by cycle while the mean keeps being computed.
module gray_adaptive_binarizer #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned INIT_THRESH  = 128,
    parameter int unsigned CNT_W        = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    gray_adaptive_binarizer_if.slave   bus,
`ifdef THRESH_OVERRIDE_EN
    input  logic                       thr_ovr_en,
    input  logic [7:0]                 thr_ovr_val,
`endif
    output logic [7:0]                 thresh,
    output logic                       frame_err
);
    localparam int unsigned SUM_W = 8 + CNT_W;
    localparam int unsigned STEP_W = $clog2(SUM_W);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W:0] DIVISOR = (CNT_W + 1)'(FRAME_PIXELS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

    typedef enum logic [1:0] {StAccum, StDivide, StDone} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_mask_q, out_sof_q, out_eol_q;
    logic [7:0]        out_gray_q;
    logic [7:0]        thresh_q, thresh_d, cmp_thr;
    logic [7:0]        pend_q, pend_d;
    logic              pend_ok_q, pend_ok_d;
    logic [SUM_W-1:0]  sum_q, sum_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              acc_on_q;      // accumulating a frame that began with sof
    logic              long_armed_q;  // frame completed, no sof seen yet
    logic              err_q;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SUM_W-1:0]  quo_q, quo_d;  // dividend shifts out, quotient shifts in
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W:0]    trial;
    logic [CNT_W-1:0]  diff;
    logic              trial_ge;
    logic              ready, xfer, apply_pend, eof;
    logic              short_err, long_err, drop_err;

    assign ready       = !out_valid_q || bus.m_ready;
    assign bus.s_ready = ready;
    assign xfer        = bus.s_valid && ready;
    assign bus.m_valid = out_valid_q;
    assign bus.m_gray  = out_gray_q;
    assign bus.m_mask  = out_mask_q;
    assign bus.m_sof   = out_sof_q;
    assign bus.m_eol   = out_eol_q;
    assign frame_err   = err_q;

    // A new mean only takes effect on an sof transfer, and that sof pixel already uses it.
    assign apply_pend = xfer && bus.s_sof && pend_ok_q;
    assign thresh_d   = apply_pend ? pend_q : thresh_q;

`ifdef THRESH_OVERRIDE_EN
    assign cmp_thr = thr_ovr_en ? thr_ovr_val : thresh_d;
    assign thresh  = thr_ovr_en ? thr_ovr_val : thresh_q;
`else
    assign cmp_thr = thresh_d;
    assign thresh  = thresh_q;
`endif

    assign sum_inc   = sum_q + SUM_W'(bus.s_gray);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign eof       = xfer && !bus.s_sof && acc_on_q && (cnt_inc == FRAME_CNT);
    assign short_err = xfer && bus.s_sof && (cnt_q != '0);
    assign long_err  = xfer && !bus.s_sof && !acc_on_q && long_armed_q;
    assign drop_err  = eof && (state_q != StAccum);

    // Restoring division step: the remainder is always below the divisor, so it fits CNT_W bits.
    assign trial    = {rem_q, quo_q[SUM_W-1]};
    assign trial_ge = (trial >= DIVISOR);
    assign diff     = CNT_W'(trial - DIVISOR);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        step_d    = step_q;
        pend_d    = pend_q;
        pend_ok_d = pend_ok_q;
        if (apply_pend) begin
            pend_ok_d = 1'b0;
        end
        unique case (state_q)
            StAccum: begin
                if (eof) begin
                    state_d = StDivide;
                    rem_d   = '0;
                    quo_d   = sum_inc;
                    step_d  = '0;
                end
            end
            StDivide: begin
                rem_d  = trial_ge ? diff : trial[CNT_W-1:0];
                quo_d  = {quo_q[SUM_W-2:0], trial_ge};
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                pend_d    = quo_q[7:0];
                pend_ok_d = 1'b1;
                state_d   = StAccum;
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAccum;
            rem_q     <= '0;
            quo_q     <= '0;
            step_q    <= '0;
            pend_q    <= 8'(INIT_THRESH);
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            step_q    <= step_d;
            pend_q    <= pend_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_gray_q   <= '0;
            out_mask_q   <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            thresh_q     <= 8'(INIT_THRESH);
            err_q        <= 1'b0;
            sum_q        <= '0;
            cnt_q        <= '0;
            acc_on_q     <= 1'b0;
            long_armed_q <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_gray_q  <= bus.s_gray;
                out_mask_q  <= (bus.s_gray >= cmp_thr);
                out_sof_q   <= bus.s_sof;
                out_eol_q   <= bus.s_eol;
            end else if (bus.m_ready) begin
                out_valid_q <= 1'b0;
            end
            thresh_q <= thresh_d;
            err_q    <= short_err | long_err | drop_err;
            if (xfer) begin
                if (bus.s_sof) begin
                    // sof restarts the frame; any partial sum is discarded
                    sum_q        <= SUM_W'(bus.s_gray);
                    cnt_q        <= CNT_W'(1);
                    acc_on_q     <= 1'b1;
                    long_armed_q <= 1'b0;
                end else if (acc_on_q) begin
                    if (eof) begin
                        sum_q        <= '0;
                        cnt_q        <= '0;
                        acc_on_q     <= 1'b0;
                        long_armed_q <= 1'b1;
                    end else begin
                        sum_q <= sum_inc;
                        cnt_q <= cnt_inc;
                    end
                end else if (long_armed_q) begin
                    // report an overlong frame once, then wait quietly for sof
                    long_armed_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gray_adaptive_binarizer.sv
module tb_gray_adaptive_binarizer;
    localparam int FP   = 16;
    localparam int CW   = 5;
    localparam int INIT = 128;
    // mean usable by an sof transfer this many edges after the end-of-frame transfer:
    // 8+CW divide steps, one DONE cycle, then the next edge
    localparam int MEAN_LAT = 8 + CW + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] thresh;
    logic       frame_err;

    always #5 clk = ~clk;

    gray_adaptive_binarizer_if bus ();

`ifdef THRESH_OVERRIDE_EN
    logic       thr_ovr_en  = 1'b0;
    logic [7:0] thr_ovr_val = 8'd0;
`endif

    gray_adaptive_binarizer #(
        .FRAME_PIXELS(FP),
        .INIT_THRESH (INIT),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef THRESH_OVERRIDE_EN
        .thr_ovr_en (thr_ovr_en),
        .thr_ovr_val(thr_ovr_val),
`endif
        .thresh     (thresh),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [7:0] gray;
        logic       sof;
        logic       mask;
        logic       eol;
    } beat_t;

    typedef struct {
        logic [7:0] gray;
        logic       sof;
        logic       mask;
        logic [7:0] thr;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    beat_t sb[$];
    int    mthr, mpend, acc_sum, acc_n, eof_cyc, div_sum;
    bit    mpend_ok, acc_on, long_armed, inflight, exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mthr       = INIT;
        mpend      = INIT;
        mpend_ok   = 0;
        acc_sum    = 0;
        acc_n      = 0;
        acc_on     = 0;
        long_armed = 0;
        inflight   = 0;
        exp_err    = 0;
    endtask

    task automatic model_xfer(input logic [7:0] g, input logic sof, input logic eol);
        beat_t b;
        if (sof) begin
            if (mpend_ok) begin
                mthr     = mpend;
                mpend_ok = 0;
            end
            if (acc_on && acc_n > 0) exp_err = 1;
            acc_on     = 1;
            acc_sum    = g;
            acc_n      = 1;
            long_armed = 0;
        end else if (acc_on) begin
            acc_sum += g;
            acc_n++;
            if (acc_n == FP) begin
                if (inflight) begin
                    exp_err = 1;
                end else begin
                    inflight = 1;
                    eof_cyc  = cyc;
                    div_sum  = acc_sum;
                end
                acc_on     = 0;
                acc_n      = 0;
                acc_sum    = 0;
                long_armed = 1;
            end
        end else if (long_armed) begin
            exp_err    = 1;
            long_armed = 0;
        end
        b.gray = g;
        b.sof  = sof;
        b.eol  = eol;
        b.mask = (int'(g) >= mthr);
        sb.push_back(b);
    endtask

    // One clock cycle: drive at negedge, check state left by the previous edge,
    // then let the model see this edge's transfer.
    task automatic cycle(input logic v, input logic [7:0] g, input logic sof, input logic eol,
                         input logic rdy, output logic xfer);
        beat_t e;
        bus.s_valid = v;
        bus.s_gray  = g;
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        bus.m_ready = rdy;
        #1;
        if (inflight && cyc >= eof_cyc + MEAN_LAT) begin
            mpend    = div_sum / FP;
            mpend_ok = 1;
            inflight = 0;
        end
        chk("m_valid", bus.m_valid, sb.size() != 0);
        chk("s_ready", bus.s_ready, (sb.size() == 0) || rdy);
        chk("thresh", thresh, mthr);
        chk("frame_err", frame_err, exp_err);
        if (bus.m_valid && rdy && sb.size() != 0) begin
            e = sb.pop_front();
            chk("m_gray", bus.m_gray, e.gray);
            chk("m_mask", bus.m_mask, e.mask);
            chk("m_sof", bus.m_sof, e.sof);
            chk("m_eol", bus.m_eol, e.eol);
        end
        xfer    = v && bus.s_ready;
        exp_err = 0;
        if (xfer) model_xfer(g, sof, eol);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic x;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, x);
    endtask

    task automatic feed(input int n, input bit rnd, input int lo, input int hi);
        int         i;
        int         guard;
        logic       x, v, r;
        logic [7:0] g;
        i     = 0;
        guard = 0;
        g     = 8'($urandom_range(hi, lo));
        while (i < n) begin
            v = rnd ? ($urandom_range(9, 0) < 7) : 1'b1;
            r = rnd ? ($urandom_range(9, 0) < 7) : 1'b1;
            cycle(v, g, i == 0, i % 4 == 3, r, x);
            if (x) begin
                i++;
                g = 8'($urandom_range(hi, lo));
            end
            guard++;
            if (guard > 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL feed_timeout: got %0d pixels, expected %0d", i, n);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_gray", bus.m_gray, 0);
        chk("rst_m_mask", bus.m_mask, 0);
        chk("rst_m_sof", bus.m_sof, 0);
        chk("rst_m_eol", bus.m_eol, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_thresh", thresh, INIT);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[48];
        logic x;
        int   acc;
        int   c;
        int   i;

        for (int k = 0; k < 16; k++) tbl[k] = '{8'd200, k == 0, 1'b1, 8'd128};
        for (int k = 0; k < 16; k++)
            tbl[16 + k] = '{(k % 2) ? 8'd220 : 8'd100, k == 0, k % 2 == 1, 8'd200};
        tbl[32] = '{8'd160, 1'b1, 1'b1, 8'd160};
        tbl[33] = '{8'd159, 1'b0, 1'b0, 8'd160};
        for (int k = 2; k < 16; k++) tbl[32 + k] = '{8'd255, 1'b0, 1'b1, 8'd160};

        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_gray  = 8'd0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        bus.m_ready = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // table: three frames, means 200, 160, 243
        for (int k = 0; k < 48; k++) begin
            if (k % 16 == 0 && k > 0) idle(20);
            cycle(1'b1, tbl[k].gray, tbl[k].sof, k % 4 == 3, 1'b1, x);
            chk("tbl_valid", bus.m_valid, 1);
            chk("tbl_gray", bus.m_gray, tbl[k].gray);
            chk("tbl_mask", bus.m_mask, tbl[k].mask);
            chk("tbl_thresh", thresh, tbl[k].thr);
        end
        idle(20);

        // back-pressure mid-frame: one pixel accepted, then stall for the rest of the window
        i   = 0;
        acc = 0;
        for (c = 0; i < FP && c < 200; c++) begin
            cycle(c != 5, 8'(10 * i + 5), i == 0, i % 4 == 3, !(c >= 6 && c < 11), x);
            if (x) i++;
            if (x && c >= 6 && c < 11) acc++;
        end
        chk("stall_accepts", acc, 1);
        idle(20);

        // short frame then a full frame of 50s
        feed(10, 0, 30, 90);
        chk("short_thresh", thresh, 80);
        feed(FP, 0, 50, 50);
        idle(20);

        // long frame: first extra pixel flags, second does not
        cycle(1'b1, 8'd7, 1'b0, 1'b0, 1'b1, x);
        cycle(1'b1, 8'd9, 1'b0, 1'b0, 1'b1, x);
        chk("long_err", frame_err, 0);
        idle(20);

        // all-zero frame gives threshold 0
        feed(FP, 0, 0, 0);
        chk("mean50_thresh", thresh, 50);
        idle(20);
        feed(FP, 0, 0, 255);
        chk("zero_thresh", thresh, 0);
        idle(4);

        // reset while dividing discards the result
        do_reset();
        idle(20);
        feed(FP, 0, 0, 255);
        chk("rst_div_thresh", thresh, INIT);
        idle(20);

        // randomized frames with random valid/ready and occasional short frames
        for (int f = 0; f < 14; f++) begin
            int lo;
            lo = $urandom_range(200, 0);
            if ($urandom_range(3, 0) == 0) feed($urandom_range(FP - 1, 2), 1, lo, lo + 55);
            else feed(FP, 1, lo, lo + 55);
            idle(20);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
